// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: takes PC addresses, reads instruction memory over req/ack,
// buffers {addr, word} in a small FIFO and presents the head to decode over valid/ready.
module instr_fetch_unit #(
  parameter int ADDR_W     = 8,
  parameter int INSTR_W    = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               pc_valid,
  output logic               pc_ready,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               flush,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_addr,
  output logic [7:0]         fetch_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic               accept;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ADDR_W-1:0]  addr_mem [FIFO_DEPTH];
  logic [INSTR_W-1:0] data_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]  hold_addr;
  logic [INSTR_W-1:0] hold_instr;

  assign fifo_full   = (count == CNT_W'(FIFO_DEPTH));
  // Accepting only in IDLE with a free slot reserves room for the eventual push.
  assign pc_ready    = rst_n & (state == IDLE) & ~fifo_full & ~flush;
  assign mem_req     = (state != IDLE);
  assign instr_valid = (count != '0);
  assign pop         = instr_valid & instr_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (pc_valid && pc_ready) begin
          accept    = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          push      = ~flush;
          state_nxt = IDLE;
        end else if (flush) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr <= '0;
    end else if (accept) begin
      mem_addr <= pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; occupancy is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= mem_addr;
      data_mem[wr_ptr] <= mem_rdata;
    end
  end

  assign instr      = instr_valid ? data_mem[rd_ptr] : hold_instr;
  assign instr_addr = instr_valid ? addr_mem[rd_ptr] : hold_addr;

  // Remembers what was last shown so the outputs hold while the FIFO is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_instr <= '0;
      hold_addr  <= '0;
    end else begin
      hold_instr <= instr;
      hold_addr  <= instr_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (pop) begin
      fetch_count <= fetch_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios, a queue-based reference model
// compared every cycle, and hand-computed literal expectations.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [7:0]  pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        flush;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  instr_addr;
  logic [7:0]  fetch_count;

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .flush(flush), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_addr(instr_addr), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Memory contents and responder
  logic [15:0] rom [256];
  int          ack_wait = 0;
  logic        spurious = 1'b0;
  int          wcnt = 0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && rst_n === 1'b1) begin
        if (wcnt >= ack_wait) begin
          mem_ack   = 1'b1;
          mem_rdata = rom[mem_addr];
          wcnt      = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack   = spurious;
        mem_rdata = 16'hDEAD;
        wcnt      = 0;
      end
    end
  end

  // Reference model: outstanding request + ordered queue of delivered entries
  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } ent_t;

  ent_t       q[$];
  ent_t       shown;
  ent_t       last_shown = '0;
  bit         pending = 1'b0;
  bit         discard = 1'b0;
  logic [7:0] pend_addr = 8'h0;
  logic [7:0] m_cnt = 8'h0;
  int         acc_cnt = 0;
  bit         m_acc, m_pop, m_ack;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        pending    = 1'b0;
        discard    = 1'b0;
        pend_addr  = 8'h0;
        m_cnt      = 8'h0;
        last_shown = '0;
      end else begin
        shown = (q.size() > 0) ? q[0] : last_shown;
        m_acc = pc_valid && !pending && q.size() < 2 && !flush;
        m_pop = q.size() > 0 && instr_ready && !flush;
        m_ack = pending && mem_ack;
        last_shown = shown;
        if (flush) begin
          q.delete();
          if (pending && !m_ack) discard = 1'b1;
        end else if (m_pop) begin
          void'(q.pop_front());
          m_cnt = m_cnt + 8'd1;
        end
        if (m_ack) begin
          if (!flush && !discard) q.push_back('{pend_addr, mem_rdata});
          pending = 1'b0;
          discard = 1'b0;
        end
        if (m_acc) begin
          pending   = 1'b1;
          pend_addr = pc;
          acc_cnt++;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      #1;
      check("pc_ready", pc_ready, rst_n && !pending && q.size() < 2 && !flush);
      check("mem_req", mem_req, pending);
      check("mem_addr", mem_addr, pend_addr);
      check("instr_valid", instr_valid, q.size() > 0);
      check("instr", instr, (q.size() > 0) ? q[0].d : last_shown.d);
      check("instr_addr", instr_addr, (q.size() > 0) ? q[0].a : last_shown.a);
      check("fetch_count", fetch_count, m_cnt);
    end
  end

  task automatic fetch(input logic [7:0] a);
    int n;
    n        = acc_cnt;
    pc       = a;
    pc_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (acc_cnt != n) break;
    end
    pc_valid = 1'b0;
    check("fetch_accept", acc_cnt != n, 1);
  endtask

  task automatic pop_one(input logic [7:0] ea);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (instr_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("pop_valid", seen, 1);
    check("pop_addr", instr_addr, ea);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {8'(i) ^ 8'h5A, 8'(i)};
    rom[55]     = 16'hA55A;
    rst_n       = 1'b0;
    pc          = 8'h0;
    pc_valid    = 1'b0;
    flush       = 1'b0;
    instr_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_pc_ready", pc_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic fetch, zero-wait memory
    ack_wait = 0;
    fetch(8'd55);
    #1;
    check("t1_mem_req", mem_req, 1);
    check("t1_mem_addr", mem_addr, 55);
    check("t1_not_yet_valid", instr_valid, 0);
    @(negedge clk);
    #1;
    check("t1_valid", instr_valid, 1);
    check("t1_instr", instr, 16'hA55A);
    check("t1_addr", instr_addr, 55);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    #1;
    check("t1_count", fetch_count, 1);
    check("t1_hold_instr", instr, 16'hA55A);

    // Wait states: request held stable across three non-ack cycles
    ack_wait = 3;
    fetch(8'd200);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t2_req_stable", mem_req, 1);
      check("t2_addr_stable", mem_addr, 200);
      check("t2_no_push", instr_valid, 0);
      @(negedge clk);
    end
    @(negedge clk);
    #1;
    check("t2_req_dropped", mem_req, 0);
    check("t2_addr", instr_addr, 200);
    pop_one(8'd200);
    #1;
    check("t2_single_push", instr_valid, 0);

    // Backpressure: full FIFO blocks pc, one pop lets 57 in
    ack_wait = 0;
    fetch(8'd55);
    fetch(8'd56);
    pc       = 8'd57;
    pc_valid = 1'b1;
    @(negedge clk);
    #1;
    check("t3_full_block", pc_ready, 0);
    @(negedge clk);
    #1;
    check("t3_full_block2", pc_ready, 0);
    check("t3_head", instr_addr, 55);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    #1;
    check("t3_slot_free", pc_ready, 1);
    @(negedge clk);
    pc_valid = 1'b0;
    pop_one(8'd56);
    pop_one(8'd57);

    // Flush in REQ, ack two cycles later: drained and discarded
    ack_wait = 2;
    fetch(8'd99);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("t4_drain_req", mem_req, 1);
    check("t4_drain_block", pc_ready, 0);
    fetch(8'd10);
    pop_one(8'd10);

    // Flush coinciding with ack, with one entry buffered
    ack_wait = 0;
    fetch(8'd20);
    fetch(8'd21);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("t4b_emptied", instr_valid, 0);
    check("t4b_idle", mem_req, 0);
    check("t4b_hold_instr", instr, 16'h4E14);
    check("t4b_hold_addr", instr_addr, 20);
    @(negedge clk);
    #1;
    check("t4b_discarded", instr_valid, 0);

    // Ack while idle is ignored
    spurious = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    spurious = 1'b0;
    @(negedge clk);
    #1;
    check("spur_no_push", instr_valid, 0);
    check("spur_no_req", mem_req, 0);
    fetch(8'd22);
    pop_one(8'd22);

    // Push and pop on the same edge keep occupancy
    fetch(8'd30);
    fetch(8'd31);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    #1;
    check("t7_still_valid", instr_valid, 1);
    check("t7_head", instr_addr, 31);
    pop_one(8'd31);

    // Reset mid-REQ with one buffered entry
    fetch(8'd1);
    @(negedge clk);
    ack_wait = 3;
    fetch(8'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_req", mem_req, 0);
    check("t5_valid", instr_valid, 0);
    check("t5_count", fetch_count, 0);
    check("t5_pc_ready", pc_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t5_ready_after", pc_ready, 1);

    // Counter wrap after 256 pops
    ack_wait    = 0;
    instr_ready = 1'b1;
    for (int i = 0; i < 255; i++) fetch(8'(i));
    repeat (3) @(negedge clk);
    #1;
    check("t6_count_255", fetch_count, 255);
    fetch(8'd255);
    repeat (3) @(negedge clk);
    #1;
    check("t6_count_wrap", fetch_count, 0);
    instr_ready = 1'b0;

    repeat (2) @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
